// File: rtl/sound_cmd_tx.sv
// sound_cmd_tx: main-CPU side of the sound-command latch link.
// Queues host command bytes in a FIFO and presents them one at a time on BD_OUT.
// For each byte it drives BUF_FUL low and pulses FIRQ low. The byte is then
// held until the sound CPU's latch read strobe (BIN_N) falls, or until a
// timeout drops it.
// Ports:
//   CLK, RESET_N        clock, synchronous active-low reset
//   CMD_DATA, CMD_WR    host push interface; CMD_RDY high while FIFO not full
//   LEVEL               FIFO occupancy (excludes the byte held in the latch)
//   BD_OUT              latch data to the sound side
//   BUF_FUL, FIRQ       active-low latch-full flag and interrupt
//   BIN_N               asynchronous active-low latch read strobe
//   TIMEOUT_ERR/CLR     sticky dropped-byte flag and its clear
module sound_cmd_tx #(
   parameter int unsigned DEPTH          = 4,
   parameter int unsigned FIRQ_CYCLES    = 8,
   parameter int unsigned GAP_CYCLES     = 2,
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input  logic                         CLK,
   input  logic                         RESET_N,
   input  logic [7:0]                   CMD_DATA,
   input  logic                         CMD_WR,
   output logic                         CMD_RDY,
   output logic [$clog2(DEPTH+1)-1:0]   LEVEL,
   output logic [7:0]                   BD_OUT,
   output logic                         BUF_FUL,
   output logic                         FIRQ,
   input  logic                         BIN_N,
   output logic                         TIMEOUT_ERR,
   input  logic                         TIMEOUT_CLR
);

   localparam int unsigned PTR_W  = $clog2(DEPTH);
   localparam int unsigned CNT_W  = $clog2(DEPTH+1);
   localparam int unsigned FCNT_W = $clog2(FIRQ_CYCLES+1);
   localparam int unsigned GCNT_W = $clog2(GAP_CYCLES+1);
   localparam int unsigned WAIT_W = 16;

   typedef enum logic [1:0] {S_IDLE, S_WAIT_ACK, S_GAP} state_t;

   state_t              r_state, w_state_nxt;
   logic [7:0]          r_mem [DEPTH];
   logic [PTR_W-1:0]    r_wr_ptr, r_rd_ptr;
   logic [CNT_W-1:0]    r_count;
   logic [7:0]          r_bd_out, w_bd_nxt;
   logic                r_buf_ful, w_buf_ful_nxt;
   logic                r_firq, w_firq_nxt;
   logic                r_err, w_err_nxt;
   logic [WAIT_W-1:0]   r_wait_cnt, w_wait_nxt;
   logic [FCNT_W-1:0]   r_firq_cnt, w_fcnt_nxt;
   logic [GCNT_W-1:0]   r_gap_cnt, w_gcnt_nxt;
   logic                r_bin_s1, r_bin_s2, r_bin_prev;
   logic                w_ack, w_timeout, w_push, w_pop;

   // ACK is a falling edge on the synchronized strobe; a level held low never re-ACKs
   assign w_ack     = r_bin_prev & ~r_bin_s2;
   assign w_timeout = (TIMEOUT_CYCLES != 0) &&
                      (r_wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));
   assign w_push    = CMD_WR & CMD_RDY;

   assign CMD_RDY     = (r_count < CNT_W'(DEPTH));
   assign LEVEL       = r_count;
   assign BD_OUT      = r_bd_out;
   assign BUF_FUL     = r_buf_ful;
   assign FIRQ        = r_firq;
   assign TIMEOUT_ERR = r_err;

   // Next-state and next-output logic for the latch handshake
   always_comb begin
      w_state_nxt   = r_state;
      w_bd_nxt      = r_bd_out;
      w_buf_ful_nxt = r_buf_ful;
      w_firq_nxt    = r_firq;
      w_err_nxt     = TIMEOUT_CLR ? 1'b0 : r_err;
      w_wait_nxt    = r_wait_cnt;
      w_fcnt_nxt    = r_firq_cnt;
      w_gcnt_nxt    = r_gap_cnt;
      w_pop         = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_count != '0) begin
               w_pop         = 1'b1;
               w_bd_nxt      = r_mem[r_rd_ptr];
               w_buf_ful_nxt = 1'b0;
               w_firq_nxt    = 1'b0;
               w_wait_nxt    = '0;
               w_fcnt_nxt    = '0;
               w_state_nxt   = S_WAIT_ACK;
            end
         end
         S_WAIT_ACK: begin
            if (w_ack || w_timeout) begin
               // ACK has priority: a simultaneous timeout does not flag an error
               w_buf_ful_nxt = 1'b1;
               w_firq_nxt    = 1'b1;
               w_gcnt_nxt    = '0;
               w_state_nxt   = S_GAP;
               if (!w_ack) w_err_nxt = 1'b1;
            end else begin
               if (r_wait_cnt != {WAIT_W{1'b1}}) w_wait_nxt = r_wait_cnt + WAIT_W'(1);
               if (!r_firq) begin
                  if (r_firq_cnt == FCNT_W'(FIRQ_CYCLES - 1)) w_firq_nxt = 1'b1;
                  else                                        w_fcnt_nxt = r_firq_cnt + FCNT_W'(1);
               end
            end
         end
         S_GAP: begin
            if (r_gap_cnt == GCNT_W'(GAP_CYCLES - 1)) w_state_nxt = S_IDLE;
            else                                      w_gcnt_nxt  = r_gap_cnt + GCNT_W'(1);
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State, FIFO, synchronizer and output registers
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         r_state    <= S_IDLE;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_bd_out   <= 8'h00;
         r_buf_ful  <= 1'b1;
         r_firq     <= 1'b1;
         r_err      <= 1'b0;
         r_wait_cnt <= '0;
         r_firq_cnt <= '0;
         r_gap_cnt  <= '0;
         r_bin_s1   <= 1'b1;
         r_bin_s2   <= 1'b1;
         r_bin_prev <= 1'b1;
         for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= 8'h00;
      end else begin
         r_state    <= w_state_nxt;
         r_bd_out   <= w_bd_nxt;
         r_buf_ful  <= w_buf_ful_nxt;
         r_firq     <= w_firq_nxt;
         r_err      <= w_err_nxt;
         r_wait_cnt <= w_wait_nxt;
         r_firq_cnt <= w_fcnt_nxt;
         r_gap_cnt  <= w_gcnt_nxt;
         r_bin_s1   <= BIN_N;
         r_bin_s2   <= r_bin_s1;
         r_bin_prev <= r_bin_s2;
         if (w_push) begin
            r_mem[r_wr_ptr] <= CMD_DATA;
            r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
